// File: rtl/perfil_pkg.sv
// rtl/perfil_pkg.sv - shared definitions for profile blocks
// Purpose: state encoding, default profile width and the profile validity rule.
// Ports: none (package).
package perfil_pkg;

  localparam int PERFIL_W_DEF = 3;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_CHECK = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE  = ST_IDLE,
    S_CHECK = ST_CHECK,
    S_HOLD  = ST_HOLD
  } state_t;

  // A code is usable only if it is neither all-zeros nor all-ones within its
  // w significant bits; bits above w are ignored.
  function automatic logic perfil_valido(input logic [31:0] code, input int w);
    logic [31:0] mask;
    logic [31:0] c;
    mask = (w >= 32) ? 32'hffff_ffff : ((32'd1 << w) - 32'd1);
    c    = code & mask;
    return (c != 32'd0) && (c != mask);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin request selector
// Purpose: pick the first set request at or above ptr, wrapping around.
// Ports: req (requests), ptr (search start), grant (one-hot),
//        idx (granted index), any (some request granted).
module rr_arbiter #(
  parameter int NUM_IF = 2,
  parameter int IDX_W  = 1
) (
  input  logic [NUM_IF-1:0] req,
  input  logic [IDX_W-1:0]  ptr,
  output logic [NUM_IF-1:0] grant,
  output logic [IDX_W-1:0]  idx,
  output logic              any
);

  int j;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    j     = 0;
    for (int k = 0; k < NUM_IF; k++) begin
      // ptr is always below NUM_IF, so one subtraction is enough to wrap
      j = int'(ptr) + k;
      if (j >= NUM_IF) j = j - NUM_IF;
      if (!any && req[j]) begin
        grant[j] = 1'b1;
        idx      = IDX_W'(j);
        any      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/transferencia_perfil_arb.sv
// rtl/transferencia_perfil_arb.sv - multi-interface profile arbiter with validity check
// Purpose: round-robin collection of profile codes, validity check, valid/ack
//          presentation, invalid-code and timeout counting.
// Ports: clk, rst (sync, active-high); if_valid/if_perfil/if_ready (request side);
//        perfil_out/perfil_src/perfil_valid/perfil_ack (consumer side);
//        err_invalid (reject pulse), err_count (saturating error count).
module transferencia_perfil_arb
  import perfil_pkg::*;
#(
  parameter int PERFIL_W = PERFIL_W_DEF,
  parameter int NUM_IF   = 2,
  parameter int ERR_W    = 4,
  parameter int TIMEOUT  = 0,
  parameter int IDX_W    = (NUM_IF > 1) ? $clog2(NUM_IF) : 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_IF-1:0]          if_valid,
  input  logic [NUM_IF*PERFIL_W-1:0] if_perfil,
  output logic [NUM_IF-1:0]          if_ready,
  output logic [PERFIL_W-1:0]        perfil_out,
  output logic [IDX_W-1:0]           perfil_src,
  output logic                       perfil_valid,
  input  logic                       perfil_ack,
  output logic                       err_invalid,
  output logic [ERR_W-1:0]           err_count
);

  localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_IF - 1);

  state_t               state;
  logic [IDX_W-1:0]     rr_ptr;
  logic [IDX_W-1:0]     sel_idx;
  logic [IDX_W-1:0]     cap_idx;
  logic [NUM_IF-1:0]    grant;
  logic                 sel_any;
  logic [PERFIL_W-1:0]  sel_code;
  logic [PERFIL_W-1:0]  cap_code;
  logic [TMR_W-1:0]     tmr;
  logic                 err_sat;

  rr_arbiter #(
    .NUM_IF (NUM_IF),
    .IDX_W  (IDX_W)
  ) u_rr (
    .req   (if_valid),
    .ptr   (rr_ptr),
    .grant (grant),
    .idx   (sel_idx),
    .any   (sel_any)
  );

  // Grant is only offered while idle and out of reset; the code is taken at
  // the same edge the grant is visible.
  assign if_ready = (!rst && state == S_IDLE) ? grant : '0;
  assign err_sat  = &err_count;

  always_comb begin
    sel_code = '0;
    for (int i = 0; i < NUM_IF; i++) begin
      if (grant[i]) sel_code = if_perfil[i*PERFIL_W +: PERFIL_W];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      rr_ptr       <= '0;
      cap_code     <= '0;
      cap_idx      <= '0;
      tmr          <= '0;
      perfil_out   <= '0;
      perfil_src   <= '0;
      perfil_valid <= 1'b0;
      err_invalid  <= 1'b0;
      err_count    <= '0;
    end else begin
      err_invalid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (sel_any) begin
            cap_code <= sel_code;
            cap_idx  <= sel_idx;
            rr_ptr   <= (NUM_IF == 1 || sel_idx == IDX_LAST) ? '0 : sel_idx + IDX_W'(1);
            state    <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (perfil_valido(32'(cap_code), PERFIL_W)) begin
            perfil_out   <= cap_code;
            perfil_src   <= cap_idx;
            perfil_valid <= 1'b1;
            tmr          <= '0;
            state        <= S_HOLD;
          end else begin
            err_invalid <= 1'b1;
            if (!err_sat) err_count <= err_count + ERR_W'(1);
            state <= S_IDLE;
          end
        end
        S_HOLD: begin
          // ack wins over a timeout expiring in the same cycle
          if (perfil_ack) begin
            perfil_valid <= 1'b0;
            perfil_out   <= '0;
            state        <= S_IDLE;
          end else if (TIMEOUT > 0 && tmr == TMR_LAST) begin
            perfil_valid <= 1'b0;
            perfil_out   <= '0;
            if (!err_sat) err_count <= err_count + ERR_W'(1);
            state <= S_IDLE;
          end else begin
            tmr <= tmr + TMR_W'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_transferencia_perfil_arb.sv
// tb/tb_transferencia_perfil_arb.sv - self-checking bench for transferencia_perfil_arb
module tb_transferencia_perfil_arb;

  localparam int W = 3;
  localparam int N = 2;
  localparam int EW = 2;
  localparam int TO = 4;
  localparam int IW = 1;
  localparam int CMAX = (1 << EW) - 1;
  localparam int ONES = (1 << W) - 1;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   if_valid = '0;
  logic [N*W-1:0] if_perfil = '0;
  logic           perfil_ack = 1'b0;
  logic [N-1:0]   if_ready;
  logic [W-1:0]   perfil_out;
  logic [IW-1:0]  perfil_src;
  logic           perfil_valid;
  logic           err_invalid;
  logic [EW-1:0]  err_count;

  transferencia_perfil_arb #(
    .PERFIL_W (W),
    .NUM_IF   (N),
    .ERR_W    (EW),
    .TIMEOUT  (TO)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .if_valid     (if_valid),
    .if_perfil    (if_perfil),
    .if_ready     (if_ready),
    .perfil_out   (perfil_out),
    .perfil_src   (perfil_src),
    .perfil_valid (perfil_valid),
    .perfil_ack   (perfil_ack),
    .err_invalid  (err_invalid),
    .err_count    (err_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: phase 0 waiting for a request, 1 judging the captured
  // code, 2 presenting it to the consumer.
  int m_phase = 0, m_ptr = 0, m_cap = 0, m_capidx = 0;
  int m_out = 0, m_src = 0, m_valid = 0, m_err = 0, m_cnt = 0, m_hold = 0;
  int g_now;
  int exp_ready;

  function automatic int find_grant(input logic [N-1:0] req, input int ptr);
    for (int k = 0; k < N; k++) begin
      int j;
      j = (ptr + k) % N;
      if (req[j]) return j;
    end
    return -1;
  endfunction

  always_comb begin
    g_now = find_grant(if_valid, m_ptr);
    exp_ready = (!rst && m_phase == 0 && g_now >= 0) ? (1 << g_now) : 0;
  end

  always @(posedge clk) begin
    if (rst) begin
      m_phase <= 0; m_ptr <= 0; m_cap <= 0; m_capidx <= 0;
      m_out <= 0; m_src <= 0; m_valid <= 0; m_err <= 0; m_cnt <= 0; m_hold <= 0;
    end else begin
      m_err <= 0;
      if (m_phase == 0) begin
        if (g_now >= 0) begin
          m_cap    <= int'(if_perfil >> (W * g_now)) & ONES;
          m_capidx <= g_now;
          m_ptr    <= (g_now + 1) % N;
          m_phase  <= 1;
        end
      end else if (m_phase == 1) begin
        if (m_cap != 0 && m_cap != ONES) begin
          m_out <= m_cap; m_src <= m_capidx; m_valid <= 1; m_hold <= 0; m_phase <= 2;
        end else begin
          m_err <= 1; m_cnt <= (m_cnt < CMAX) ? m_cnt + 1 : CMAX; m_phase <= 0;
        end
      end else begin
        if (perfil_ack) begin
          m_out <= 0; m_valid <= 0; m_phase <= 0;
        end else if (m_hold + 1 == TO) begin
          m_out <= 0; m_valid <= 0; m_phase <= 0;
          m_cnt <= (m_cnt < CMAX) ? m_cnt + 1 : CMAX;
        end else begin
          m_hold <= m_hold + 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("if_ready", 32'(if_ready), exp_ready);
      chk("perfil_out", 32'(perfil_out), m_out);
      chk("perfil_valid", 32'(perfil_valid), m_valid);
      if (m_valid != 0) chk("perfil_src", 32'(perfil_src), m_src);
      chk("err_invalid", 32'(err_invalid), m_err);
      chk("err_count", 32'(err_count), m_cnt);
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    tick;
    tick;
    rst = 1'b0;
  endtask

  int srcs[$];
  int sat_exp[5] = '{1, 2, 3, 3, 3};

  initial begin
    // reset, with a request pending that must not be granted
    rst = 1'b1;
    if_valid = 2'b01;
    if_perfil = {3'b000, 3'b011};
    tick;
    cmp_en = 1'b1;
    chk("lit_ready_in_reset", 32'(if_ready), 0);
    tick;
    chk("lit_rst_out", 32'(perfil_out), 0);
    chk("lit_rst_valid", 32'(perfil_valid), 0);
    chk("lit_rst_cnt", 32'(err_count), 0);

    // single valid code from interface 0
    rst = 1'b0;
    #1;
    chk("lit_grant0", 32'(if_ready), 32'b01);
    tick;
    if_valid = '0;
    tick;
    chk("lit_valid_T1", 32'(perfil_valid), 1);
    chk("lit_out_011", 32'(perfil_out), 3);
    chk("lit_src0", 32'(perfil_src), 0);
    perfil_ack = 1'b1;
    tick;
    perfil_ack = 1'b0;
    chk("lit_out_after_ack", 32'(perfil_out), 0);

    // invalid codes: all-ones then all-zeros
    if_valid = 2'b01; if_perfil = {3'b000, 3'b111};
    tick;
    if_valid = '0;
    tick;
    chk("lit_errp_111", 32'(err_invalid), 1);
    chk("lit_cnt1", 32'(err_count), 1);
    tick;
    chk("lit_errp_clear", 32'(err_invalid), 0);
    if_valid = 2'b01; if_perfil = {3'b000, 3'b000};
    tick;
    if_valid = '0;
    tick;
    chk("lit_errp_000", 32'(err_invalid), 1);
    chk("lit_cnt2", 32'(err_count), 2);
    chk("lit_inval_no_valid", 32'(perfil_valid), 0);
    tick;

    // both interfaces requesting continuously, ack always high
    do_reset;
    if_valid = 2'b11; if_perfil = {3'b010, 3'b001}; perfil_ack = 1'b1;
    for (int c = 0; c < 12; c++) begin
      tick;
      if (perfil_valid) srcs.push_back(int'(perfil_src));
    end
    if_valid = '0; perfil_ack = 1'b0;
    chk("lit_rr_count", srcs.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < srcs.size()) chk("lit_rr_src", srcs[i], i % 2);
    end
    tick;
    tick;

    // saturation of the 2-bit error counter
    do_reset;
    for (int k = 0; k < 5; k++) begin
      if_valid = 2'b10;
      if_perfil = (k % 2 == 0) ? {3'b111, 3'b000} : {3'b000, 3'b000};
      tick;
      if_valid = '0;
      tick;
      chk("lit_sat_cnt", 32'(err_count), sat_exp[k]);
      tick;
    end

    // timeout after exactly four unacknowledged HOLD cycles
    do_reset;
    if_valid = 2'b01; if_perfil = {3'b000, 3'b101};
    tick;
    if_valid = '0;
    tick;
    tick; tick; tick;
    chk("lit_to_still_valid", 32'(perfil_valid), 1);
    tick;
    chk("lit_to_dropped", 32'(perfil_valid), 0);
    chk("lit_to_cnt", 32'(err_count), 1);

    // ack in the fourth HOLD cycle beats the timeout
    if_valid = 2'b01;
    tick;
    if_valid = '0;
    tick;
    tick; tick; tick;
    perfil_ack = 1'b1;
    tick;
    perfil_ack = 1'b0;
    chk("lit_ack4_valid", 32'(perfil_valid), 0);
    chk("lit_ack4_cnt", 32'(err_count), 1);

    // reset in the middle of HOLD, profile from interface 1
    if_valid = 2'b10; if_perfil = {3'b101, 3'b000};
    tick;
    if_valid = '0;
    tick;
    chk("lit_hold_out", 32'(perfil_out), 5);
    chk("lit_hold_src", 32'(perfil_src), 1);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("lit_mid_rst_out", 32'(perfil_out), 0);
    chk("lit_mid_rst_valid", 32'(perfil_valid), 0);
    chk("lit_mid_rst_src", 32'(perfil_src), 0);
    chk("lit_mid_rst_cnt", 32'(err_count), 0);
    tick;
    tick;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
